// File: rtl/oc8051_muldiv_unit_pkg.sv
// Shared constants and payload types for the oc8051 iterative multiply/divide unit.
package oc8051_muldiv_unit_pkg;

    localparam int unsigned DATA_W        = 8;
    localparam int unsigned STEP_N        = 4;
    localparam int unsigned BITS_PER_STEP = 2;
    localparam int unsigned CNT_W         = 2;
    localparam int unsigned PROD_W        = 2 * DATA_W;

    typedef struct packed {
        logic [DATA_W-1:0] rem;
        logic [DATA_W-1:0] quot;
    } div_part_t;

endpackage

// File: rtl/oc8051_muldiv_unit_if.sv
// Operand/result bundle between the ALU and the multiply/divide unit.
interface oc8051_muldiv_unit_if;
    import oc8051_muldiv_unit_pkg::*;

    logic              enable_mul;
    logic              enable_div;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [DATA_W-1:0] mul_des1;
    logic [DATA_W-1:0] mul_des2;
    logic              mul_ov;
    logic [DATA_W-1:0] div_des1;
    logic [DATA_W-1:0] div_des2;
    logic              div_ov;
    logic [CNT_W-1:0]  mul_cnt;
    logic [CNT_W-1:0]  div_cnt;

    modport master (
        output enable_mul, enable_div, src1, src2,
        input  mul_des1, mul_des2, mul_ov, div_des1, div_des2, div_ov, mul_cnt, div_cnt
    );

    modport slave (
        input  enable_mul, enable_div, src1, src2,
        output mul_des1, mul_des2, mul_ov, div_des1, div_des2, div_ov, mul_cnt, div_cnt
    );

endinterface

// File: rtl/oc8051_div_step.sv
// One iteration of restoring division: shifts in two dividend bits, MSB first.
module oc8051_div_step
    import oc8051_muldiv_unit_pkg::*;
(
    input  logic [DATA_W-1:0] rem_in,
    input  logic [DATA_W-1:0] q_in,
    input  logic [1:0]        dvd_bits,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_out,
    output logic [DATA_W-1:0] q_out
);

    logic [DATA_W:0] trial1;
    logic [DATA_W:0] trial2;
    logic [DATA_W:0] rem1;
    logic [DATA_W:0] rem2;
    logic            qbit1;
    logic            qbit2;

    // Trial values keep a ninth bit so a remainder >= 0x80 shifted left still compares correctly.
    always_comb begin
        trial1  = {rem_in, dvd_bits[1]};
        qbit1   = (trial1 >= {1'b0, divisor});
        rem1    = qbit1 ? (trial1 - {1'b0, divisor}) : trial1;
        trial2  = {rem1[DATA_W-1:0], dvd_bits[0]};
        qbit2   = (trial2 >= {1'b0, divisor});
        rem2    = qbit2 ? (trial2 - {1'b0, divisor}) : trial2;
        rem_out = rem2[DATA_W-1:0];
        q_out   = {q_in[DATA_W-3:0], qbit1, qbit2};
    end

endmodule

// File: rtl/oc8051_muldiv_unit.sv
// Iterative 8x8 unsigned MUL AB / DIV AB engines, two operand bits per clock, four clocks per op.
module oc8051_muldiv_unit
    import oc8051_muldiv_unit_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    oc8051_muldiv_unit_if.slave    bus
);

    logic [CNT_W-1:0]  mul_cnt_q, mul_cnt_d;
    logic [PROD_W-1:0] mul_part_q, mul_part_d;
    logic [CNT_W-1:0]  div_cnt_q, div_cnt_d;
    div_part_t         div_part_q, div_part_d;

    logic [1:0]        mul_bits;
    logic [2:0]        mul_shamt;
    logic [PROD_W-1:0] mul_pp;
    logic [PROD_W-1:0] mul_res;

    logic [2:0]        div_base;
    logic [1:0]        div_bits;
    logic [DATA_W-1:0] div_rem_in;
    logic [DATA_W-1:0] div_q_in;
    logic [DATA_W-1:0] div_rem_out;
    logic [DATA_W-1:0] div_q_out;

    // Multiply step: add src1 * (current multiplier bit pair) at weight 2k to the running product.
    always_comb begin
        mul_shamt = {mul_cnt_q, 1'b0};
        mul_bits  = bus.src2[mul_shamt +: 2];
        mul_pp    = PROD_W'(bus.src1) * PROD_W'(mul_bits);
        mul_res   = ((mul_cnt_q == '0) ? '0 : mul_part_q) + (mul_pp << mul_shamt);
    end

    // Divide step: dividend bits are consumed MSB first, so step k reads bits 7-2k and 6-2k.
    always_comb begin
        div_base   = {~div_cnt_q, 1'b0};
        div_bits   = bus.src1[div_base +: 2];
        div_rem_in = (div_cnt_q == '0) ? '0 : div_part_q.rem;
        div_q_in   = (div_cnt_q == '0) ? '0 : div_part_q.quot;
    end

    oc8051_div_step u_div_step (
        .rem_in   (div_rem_in),
        .q_in     (div_q_in),
        .dvd_bits (div_bits),
        .divisor  (bus.src2),
        .rem_out  (div_rem_out),
        .q_out    (div_q_out)
    );

    // Next state: an idle cycle restarts the counter, the partial result holds.
    always_comb begin
        mul_cnt_d  = '0;
        mul_part_d = mul_part_q;
        div_cnt_d  = '0;
        div_part_d = div_part_q;
        if (bus.enable_mul) begin
            mul_cnt_d  = mul_cnt_q + CNT_W'(1);
            mul_part_d = mul_res;
        end
        if (bus.enable_div) begin
            div_cnt_d       = div_cnt_q + CNT_W'(1);
            div_part_d.rem  = div_rem_out;
            div_part_d.quot = div_q_out;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_cnt_q  <= '0;
            mul_part_q <= '0;
            div_cnt_q  <= '0;
            div_part_q <= '0;
        end else begin
            mul_cnt_q  <= mul_cnt_d;
            mul_part_q <= mul_part_d;
            div_cnt_q  <= div_cnt_d;
            div_part_q <= div_part_d;
        end
    end

    // The ALU samples these in step 3; earlier steps show partial results.
    assign bus.mul_des1 = mul_res[DATA_W-1:0];
    assign bus.mul_des2 = mul_res[PROD_W-1:DATA_W];
    assign bus.mul_ov   = |mul_res[PROD_W-1:DATA_W];
    assign bus.div_des1 = div_q_out;
    assign bus.div_des2 = div_rem_out;
    assign bus.div_ov   = (bus.src2 == '0);
    assign bus.mul_cnt  = mul_cnt_q;
    assign bus.div_cnt  = div_cnt_q;

endmodule

// File: tb/tb_oc8051_muldiv_unit.sv
// Self-checking bench for oc8051_muldiv_unit: directed table, corner sequences, random ops vs arithmetic model.
module tb_oc8051_muldiv_unit;

    logic clk;
    logic rst;

    oc8051_muldiv_unit_if bus_if ();

    oc8051_muldiv_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       is_div;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp1;
        logic [7:0] exp2;
        logic       exp_ov;
    } vec_t;

    int n_vec;
    int n_err;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Starts at a negedge with the counters at 0; returns at the negedge inside step 3.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic m, input logic d);
        bus_if.src1       = a;
        bus_if.src2       = b;
        bus_if.enable_mul = m;
        bus_if.enable_div = d;
        repeat (3) @(negedge clk);
    endtask

    task automatic idle();
        bus_if.enable_mul = 1'b0;
        bus_if.enable_div = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_mul(input string name, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        chk({name, ".mul_des1"}, 16'(bus_if.mul_des1), 16'(p[7:0]));
        chk({name, ".mul_des2"}, 16'(bus_if.mul_des2), 16'(p[15:8]));
        chk({name, ".mul_ov"},   16'(bus_if.mul_ov),   16'(p > 16'h00FF));
    endtask

    task automatic check_div(input string name, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] q;
        logic [7:0] r;
        if (b == 8'h00) begin
            q = 8'hFF;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
        chk({name, ".div_des1"}, 16'(bus_if.div_des1), 16'(q));
        chk({name, ".div_des2"}, 16'(bus_if.div_des2), 16'(r));
        chk({name, ".div_ov"},   16'(bus_if.div_ov),   16'(b == 8'h00));
    endtask

    vec_t tbl[12];

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] nb;
        n_vec = 0;
        n_err = 0;

        tbl[0]  = '{1'b0, 8'h0C, 8'h15, 8'hFC, 8'h00, 1'b0};
        tbl[1]  = '{1'b0, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1};
        tbl[2]  = '{1'b0, 8'h00, 8'h37, 8'h00, 8'h00, 1'b0};
        tbl[3]  = '{1'b0, 8'h80, 8'h02, 8'h00, 8'h01, 1'b1};
        tbl[4]  = '{1'b0, 8'h0F, 8'h11, 8'hFF, 8'h00, 1'b0};
        tbl[5]  = '{1'b1, 8'hC8, 8'h07, 8'h1C, 8'h04, 1'b0};
        tbl[6]  = '{1'b1, 8'h55, 8'h00, 8'hFF, 8'h55, 1'b1};
        tbl[7]  = '{1'b1, 8'h07, 8'hC8, 8'h00, 8'h07, 1'b0};
        tbl[8]  = '{1'b1, 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0};
        tbl[9]  = '{1'b1, 8'hFF, 8'hFF, 8'h01, 8'h00, 1'b0};
        tbl[10] = '{1'b1, 8'hFF, 8'h81, 8'h01, 8'h7E, 1'b0};
        tbl[11] = '{1'b1, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b1};

        // Reset: counters clear and step-0 outputs are defined while held in reset.
        rst               = 1'b0;
        bus_if.enable_mul = 1'b0;
        bus_if.enable_div = 1'b0;
        bus_if.src1       = 8'h03;
        bus_if.src2       = 8'h02;
        repeat (2) @(negedge clk);
        chk("reset.mul_cnt", 16'(bus_if.mul_cnt), 16'h0);
        chk("reset.div_cnt", 16'(bus_if.div_cnt), 16'h0);
        bus_if.enable_mul = 1'b1;
        #1;
        chk("reset.step0_des1", 16'(bus_if.mul_des1), 16'h06);
        chk("reset.step0_des2", 16'(bus_if.mul_des2), 16'h00);
        @(negedge clk);
        chk("reset.hold_cnt", 16'(bus_if.mul_cnt), 16'h0);
        bus_if.enable_mul = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // Directed table.
        foreach (tbl[i]) begin
            run_op(tbl[i].a, tbl[i].b, ~tbl[i].is_div, tbl[i].is_div);
            if (tbl[i].is_div) begin
                chk($sformatf("tbl%0d.div_des1", i), 16'(bus_if.div_des1), 16'(tbl[i].exp1));
                chk($sformatf("tbl%0d.div_des2", i), 16'(bus_if.div_des2), 16'(tbl[i].exp2));
                chk($sformatf("tbl%0d.div_ov", i),   16'(bus_if.div_ov),   16'(tbl[i].exp_ov));
            end else begin
                chk($sformatf("tbl%0d.mul_des1", i), 16'(bus_if.mul_des1), 16'(tbl[i].exp1));
                chk($sformatf("tbl%0d.mul_des2", i), 16'(bus_if.mul_des2), 16'(tbl[i].exp2));
                chk($sformatf("tbl%0d.mul_ov", i),   16'(bus_if.mul_ov),   16'(tbl[i].exp_ov));
            end
            idle();
        end

        // Abort: two enabled cycles, one idle cycle, then a full 0x10*0x10.
        bus_if.src1       = 8'hAB;
        bus_if.src2       = 8'hCD;
        bus_if.enable_mul = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort.mid_cnt", 16'(bus_if.mul_cnt), 16'h2);
        idle();
        chk("abort.restart_cnt", 16'(bus_if.mul_cnt), 16'h0);
        run_op(8'h10, 8'h10, 1'b1, 1'b0);
        chk("abort.step3_cnt", 16'(bus_if.mul_cnt), 16'h3);
        chk("abort.mul_des1", 16'(bus_if.mul_des1), 16'h00);
        chk("abort.mul_des2", 16'(bus_if.mul_des2), 16'h01);
        chk("abort.mul_ov",   16'(bus_if.mul_ov),   16'h1);
        idle();

        // Asynchronous reset mid-divide at step 2, then 0x64 / 0x0A.
        bus_if.src1       = 8'hC8;
        bus_if.src2       = 8'h07;
        bus_if.enable_div = 1'b1;
        repeat (2) @(negedge clk);
        chk("rstmid.pre_cnt", 16'(bus_if.div_cnt), 16'h2);
        #2 rst = 1'b0;
        #1;
        chk("rstmid.div_cnt", 16'(bus_if.div_cnt), 16'h0);
        @(negedge clk);
        rst = 1'b1;
        run_op(8'h64, 8'h0A, 1'b0, 1'b1);
        chk("rstmid.div_des1", 16'(bus_if.div_des1), 16'h0A);
        chk("rstmid.div_des2", 16'(bus_if.div_des2), 16'h00);
        chk("rstmid.div_ov",   16'(bus_if.div_ov),   16'h0);
        idle();

        // Back-to-back: enable held, operands change after each step-3 sample.
        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (i == 2) rb = 8'h00;
            run_op(ra, rb, 1'b1, 1'b1);
            check_mul($sformatf("b2b%0d", i), ra, rb);
            check_div($sformatf("b2b%0d", i), ra, rb);
            @(negedge clk);
            chk($sformatf("b2b%0d.wrap", i), 16'(bus_if.div_cnt), 16'h0);
        end
        idle();

        // Random single operations against the arithmetic model.
        for (int i = 0; i < 60; i++) begin
            ra = 8'($urandom);
            nb = 8'($urandom_range(0, 7));
            rb = (nb == 8'h0) ? 8'h00 : 8'($urandom);
            if (i % 2 == 0) begin
                run_op(ra, rb, 1'b1, 1'b0);
                check_mul($sformatf("rnd%0d", i), ra, rb);
            end else begin
                run_op(ra, rb, 1'b0, 1'b1);
                check_div($sformatf("rnd%0d", i), ra, rb);
            end
            idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/oc8051_muldiv_unit.md
Name: oc8051_muldiv_unit

Overview:
- Iterative 8-bit unsigned multiplier and divider serving the oc8051 ALU MUL AB and DIV AB opcodes.
- Each engine resolves 2 operand bits per clock and finishes in 4 clock cycles.
- Outputs are combinational from the engine's internal state plus the current step; the ALU samples them at the end of the 4th enabled cycle into A (des1) and B (des2).
- Multiply and divide engines are independent; each is started by its own enable.

Parameters:
none (fixed 8-bit datapath, 4-step iteration)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; asynchronous, active-low (0 = reset)
enable_mul  input  1  multiply running; held high for 4 consecutive cycles
enable_div  input  1  divide running; held high for 4 consecutive cycles
src1  input  8  operand A (multiplicand / dividend); stable while enabled
src2  input  8  operand B (multiplier / divisor); stable while enabled
mul_des1  output  8  product low byte (to A)
mul_des2  output  8  product high byte (to B)
mul_ov  output  1  1 when product > 0xFF
div_des1  output  8  quotient (to A)
div_des2  output  8  remainder (to B)
div_ov  output  1  1 when divisor == 0

Behaviour:
- Each engine has a 2-bit step counter (0..3) and a partial-result register.
  - Multiply partial: 16-bit.
  - Divide partial: 8-bit remainder plus 8-bit quotient.
- rst=0 (asynchronous) clears both counters and partial registers to 0. A reset mid-operation aborts it; the next enabled cycle is step 0.
- Enable low: counter is forced to 0 at the next clock edge and the partial register holds. Outputs are don't-care.
- Enable high: on each rising edge the counter increments mod 4 (3 -> 0) and the partial register captures the current step result.
- Multiply step k:
  - result = (k==0 ? 0 : partial) + ((src1 * src2[2k+1:2k]) << 2k), 16-bit.
  - mul_des1 = result[7:0]; mul_des2 = result[15:8]; mul_ov = |result[15:8].
- Divide step k: restoring division, quotient bits 7-2k and 6-2k, MSB first.
  - Per bit: rem = {rem[6:0]/prior bits, next dividend bit}; if rem >= src2 then rem -= src2, qbit = 1, else qbit = 0.
  - Step 0 starts from rem = 0, q = 0.
  - div_des1 = quotient, div_des2 = remainder, div_ov = (src2 == 8'h00).
- Outputs are final only during step 3 (the 4th consecutive enabled cycle). Values in steps 0..2 are partial and not to be used.
- Divide by zero: the algorithm naturally yields quotient 0xFF and remainder = src1. This is the required result, with div_ov=1.
- Both enables high simultaneously: both engines run independently. The ALU never does this.
- Back-to-back operations: after step 3 the counter wraps to 0, so a continuously held enable starts a new 4-cycle operation immediately.
- All arithmetic is unsigned. No X propagation on outputs after reset.

Decomposition:
- Shared package: constants for step count (4), bits per step (2), data width (8).
- Top oc8051_muldiv_unit instantiates:
  - the multiply engine inline;
  - one sub-module oc8051_div_step: combinational 2-bit restoring-division step (inputs rem_in, q_in, dividend bit pair, divisor; outputs rem_out, q_out).

Test Plan:
- MUL: src1=0x0C, src2=0x15, enable_mul high 4 cycles -> step 3: mul_des1=0xFC, mul_des2=0x00, mul_ov=0.
- MUL: src1=0xFF, src2=0xFF -> step 3: mul_des1=0x01, mul_des2=0xFE, mul_ov=1.
- DIV: src1=0xC8, src2=0x07 -> step 3: div_des1=0x1C, div_des2=0x04, div_ov=0.
- DIV by zero: src1=0x55, src2=0x00 -> step 3: div_ov=1, div_des1=0xFF, div_des2=0x55.
- Abort: enable_mul high 2 cycles, low 1 cycle, then 0x10*0x10 for 4 cycles -> counter restarts at 0; step 3: mul_des1=0x00, mul_des2=0x01, mul_ov=1.
- Reset: assert rst=0 mid-divide (step 2), release, run 0x64/0x0A for 4 cycles -> div_des1=0x0A, div_des2=0x00; counters read 0 immediately on reset without a clock edge.
